stream_mux: RTL and testbench
=============================

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..64.
REQ-003 Parameter SEL_W, default 2: select width, equal to clog2(N_CH).
REQ-004 Port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port mode, input, 1 bit: 0 selects FIXED mode (use sel); 1 selects RR mode (round-robin).
REQ-007 Port sel, input, SEL_W bits: channel index used in FIXED mode.
REQ-008 Port in_data, input, N_CH*W bits: flattened input data; channel i occupies bits [i*W +: W].
REQ-009 Port in_valid, input, N_CH bits: per-channel valid.
REQ-010 Port in_ready, output, N_CH bits: per-channel ready; combinational.
REQ-011 Port out_data, output, W bits: registered output data.
REQ-012 Port out_ch, output, SEL_W bits: registered index of the channel that sourced out_data.
REQ-013 Port out_valid, output, 1 bit: registered output valid.
REQ-014 Port out_ready, input, 1 bit: downstream ready.
REQ-015 Port xfer_cnt, output, 16 bits: count of completed output transfers.

Function
REQ-016 Define load = !out_valid || out_ready; the output register may accept new data only when load is 1.
REQ-017 In FIXED mode, grant channel sel when sel < N_CH; if sel >= N_CH, grant no channel.
REQ-018 In RR mode, grant the first channel with in_valid=1, searching upward from (last_grant+1) mod N_CH with wrap-around.
REQ-019 in_ready[g] = load for the granted channel g; in_ready is 0 for every other channel, and all bits are 0 when there is no grant.
REQ-020 A channel transfer occurs when in_valid[g] && in_ready[g]; on that edge, out_data <= channel g data, out_ch <= g, out_valid <= 1.
REQ-021 Latency is 1 cycle from input transfer to out_valid.
REQ-022 Full throughput is 1 word per cycle while out_ready=1.
REQ-023 If load=1 and no channel transfers, out_valid <= 0.
REQ-024 While out_valid && !out_ready, out_data, out_ch and out_valid hold stable and all in_ready bits are 0.
REQ-025 last_grant updates only on an RR-mode input transfer; FIXED-mode transfers leave it unchanged.
REQ-026 A mode or sel change takes effect combinationally on the next arbitration; it never alters data already in the output register.
REQ-027 xfer_cnt increments by 1 on every edge where out_valid && out_ready, and wraps from 0xFFFF to 0.
REQ-028 No channel data is dropped or duplicated: every input transfer yields exactly one output transfer, in order.

Reset
REQ-029 When rst_n=0 at a clock edge: out_valid <= 0, out_data <= 0, out_ch <= 0, xfer_cnt <= 0, last_grant <= N_CH-1 (so channel 0 has first RR priority).
REQ-030 While rst_n=0, in_ready is all 0.
REQ-031 Reset mid-transfer discards the held output word without an output handshake.

Structure
REQ-032 The shared package stream_mux_pkg holds the mode constants MODE_FIXED=0 and MODE_RR=1 and the xfer_cnt width constant (16).
REQ-033 The round-robin search is implemented in the sub-module rr_arbiter (inputs: req, last_grant; outputs: grant_idx, grant_vld); it is purely combinational.
REQ-034 The top level contains only the output register, last_grant, the counter and the ready/grant glue logic.

Verification
REQ-035 Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, xfer_cnt=0.
REQ-036 FIXED mode: mode=0, sel=2, in_valid=1111, ch2 data=0xA5, out_ready=1 -> in_ready=0100; next cycle out_data=0xA5, out_ch=2, out_valid=1.
REQ-037 RR fairness: mode=1, in_valid=1111 constant, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 and xfer_cnt=7 after the eighth beat's output edge.
REQ-038 RR skip and wrap: mode=1, in_valid=1001, last_grant=0 -> grant 3, then grant 0.
REQ-039 Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid -> out_data is unchanged, in_ready=0000, no counter increment; out_ready=1 -> one transfer, then the next word is accepted.
REQ-040 Out-of-range sel and counter wrap: N_CH=3, sel=3 -> no grant and out_valid drops to 0; force 65536 transfers -> xfer_cnt returns to 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream_mux slice: mode encodings and the
// transfer counter width.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Purely combinational round-robin search: first requester strictly after
// last_grant, wrapping around, so last_grant itself has lowest priority.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int off = N_CH; off >= 1; off--) begin
      if (req[(int'(last_grant) + off) % N_CH]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'((int'(last_grant) + off) % N_CH);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel stream multiplexer with fixed-select or round-robin arbitration
// into a single registered output stage, plus a wrapping transfer counter.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*W-1:0]     in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [W-1:0]          out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  logic [W-1:0]          out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_ch_q, out_ch_d;
  logic                  out_valid_q, out_valid_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [SEL_W-1:0]      last_grant_q, last_grant_d;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             load;
  logic             xfer;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .grant_idx  (rr_idx),
    .grant_vld  (rr_vld)
  );

  // An out-of-range fixed select grants nothing, so that channel stalls.
  always_comb begin
    load = !out_valid_q || out_ready;
    if (mode == MODE_RR) begin
      grant_idx = rr_idx;
      grant_vld = rr_vld;
    end else begin
      grant_idx = sel;
      grant_vld = (int'(sel) < N_CH);
    end
    in_ready = '0;
    if (rst_n && grant_vld && load) begin
      in_ready[grant_idx] = 1'b1;
    end
    xfer = |(in_ready & in_valid);
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    xfer_cnt_d   = xfer_cnt_q;
    if (xfer) begin
      out_data_d  = in_data[int'(grant_idx)*W +: W];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        last_grant_d = grant_idx;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      xfer_cnt_d = xfer_cnt_q + 1'b1;
    end
  end

  // Reset points last_grant at the top channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      xfer_cnt_q   <= '0;
      last_grant_q <= SEL_W'(N_CH - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      xfer_cnt_q   <= xfer_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed scenarios on a 4-channel and a
// 3-channel instance, plus randomized traffic against a behavioural model.
module tb_stream_mux;

  logic clk = 1'b0;
  logic rst_n;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  logic        mode_3;
  logic [1:0]  sel_3;
  logic [23:0] in_data_3;
  logic [2:0]  in_valid_3;
  logic [2:0]  in_ready_3;
  logic [7:0]  out_data_3;
  logic [1:0]  out_ch_3;
  logic        out_valid_3;
  logic        out_ready_3;
  logic [15:0] xfer_cnt_3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_mux #(.N_CH(4), .W(8), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  stream_mux #(.N_CH(3), .W(8), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode_3), .sel(sel_3),
    .in_data(in_data_3), .in_valid(in_valid_3), .in_ready(in_ready_3),
    .out_data(out_data_3), .out_ch(out_ch_3), .out_valid(out_valid_3),
    .out_ready(out_ready_3), .xfer_cnt(xfer_cnt_3)
  );

  // Called at a falling edge; leaves the bench at the next falling edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 1'b0; sel = 2'd0; in_data = 32'h44332211; in_valid = 4'hF; out_ready = 1'b1;
    mode_3 = 1'b0; sel_3 = 2'd0; in_data_3 = 24'h332211; in_valid_3 = 3'h7; out_ready_3 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (xfer_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_xfer_cnt: got %0d expected 0", xfer_cnt); end
    total++; if (out_data !== 8'd0 || out_ch !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_regs: got data=%h ch=%0d expected 00/0", out_data, out_ch); end
    total++; if (in_ready_3 !== 3'b000 || out_valid_3 !== 1'b0) begin bad++; $display("[TB] FAIL reset_dut3: got rdy=%b vld=%b expected 000/0", in_ready_3, out_valid_3); end
    @(negedge clk);
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = {8'h44, 8'hA5, 8'h22, 8'h11}; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL fixed_in_ready: got %b expected 0100", in_ready); end
    @(negedge clk);
    total++; if (out_data !== 8'hA5) begin bad++; $display("[TB] FAIL fixed_out_data: got %h expected a5", out_data); end
    total++; if (out_ch !== 2'd2) begin bad++; $display("[TB] FAIL fixed_out_ch: got %0d expected 2", out_ch); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL fixed_out_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_rr_fair();
    do_reset();
    mode = 1'b1; in_valid = 4'hF; in_data = $urandom; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== in_data[(i % 4)*8 +: 8]) begin
        bad++;
        $display("[TB] FAIL rr_fair_beat%0d: got vld=%b ch=%0d data=%h expected 1/%0d/%h",
                 i, out_valid, out_ch, out_data, i % 4, in_data[(i % 4)*8 +: 8]);
      end
    end
    total++; if (xfer_cnt !== 16'd7) begin bad++; $display("[TB] FAIL rr_fair_cnt: got %0d expected 7", xfer_cnt); end
  endtask

  task automatic test_rr_skip_wrap();
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; in_data = 32'hD4C3B2A1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL skip_first: got %b expected 0001", in_ready); end
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("[TB] FAIL skip_grant3: got %b expected 1000", in_ready); end
    @(negedge clk);
    total++; if (out_ch !== 2'd3 || out_data !== 8'hD4) begin bad++; $display("[TB] FAIL skip_out3: got ch=%0d data=%h expected 3/d4", out_ch, out_data); end
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL wrap_grant0: got %b expected 0001", in_ready); end
    @(negedge clk);
    total++; if (out_ch !== 2'd0 || out_data !== 8'hA1) begin bad++; $display("[TB] FAIL wrap_out0: got ch=%0d data=%h expected 0/a1", out_ch, out_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00001100; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_data = 32'h00002200;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_in_ready%0d: got %b expected 0000", i, in_ready); end
      @(negedge clk);
      total++;
      if (out_data !== 8'h11 || out_valid !== 1'b1 || xfer_cnt !== 16'd0) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d: got data=%h vld=%b cnt=%0d expected 11/1/0", i, out_data, out_valid, xfer_cnt);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("[TB] FAIL bp_release_rdy: got %b expected 0010", in_ready); end
    @(negedge clk);
    total++; if (out_data !== 8'h22 || xfer_cnt !== 16'd1) begin bad++; $display("[TB] FAIL bp_release: got data=%h cnt=%0d expected 22/1", out_data, xfer_cnt); end
    in_valid = 4'b0000;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd2) begin bad++; $display("[TB] FAIL bp_drain: got vld=%b cnt=%0d expected 0/2", out_valid, xfer_cnt); end
    in_valid = 4'b0010; in_data = 32'h00003300; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_rdy: got %b expected 0000", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd0) begin bad++; $display("[TB] FAIL midreset_flush: got vld=%b cnt=%0d expected 0/0", out_valid, xfer_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_oob_sel();
    do_reset();
    mode_3 = 1'b0; sel_3 = 2'd0; in_valid_3 = 3'b111; in_data_3 = 24'h77665A; out_ready_3 = 1'b1;
    @(negedge clk);
    total++; if (out_valid_3 !== 1'b1 || out_data_3 !== 8'h5A) begin bad++; $display("[TB] FAIL oob_load: got vld=%b data=%h expected 1/5a", out_valid_3, out_data_3); end
    sel_3 = 2'd3;
    #1;
    total++; if (in_ready_3 !== 3'b000) begin bad++; $display("[TB] FAIL oob_in_ready: got %b expected 000", in_ready_3); end
    @(negedge clk);
    total++; if (out_valid_3 !== 1'b0 || xfer_cnt_3 !== 16'd1) begin bad++; $display("[TB] FAIL oob_drop: got vld=%b cnt=%0d expected 0/1", out_valid_3, xfer_cnt_3); end
  endtask

  // Model: a word is pending or not; arbitration is recomputed from the rules each cycle.
  task automatic test_random();
    logic [9:0]  pend_q[$];
    logic [9:0]  exp_word;
    bit          m_valid;
    logic [7:0]  m_data;
    logic [1:0]  m_ch;
    logic [15:0] m_cnt;
    int          m_last;
    int          g;
    bit          gv;
    bit          ld;
    logic [3:0]  exp_rdy;
    do_reset();
    m_valid = 0; m_data = '0; m_ch = '0; m_cnt = '0; m_last = 3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ld = !m_valid || out_ready;
      gv = 0; g = 0;
      if (mode == 1'b0) begin
        gv = 1; g = int'(sel);
      end else begin
        for (int k = 1; k <= 4; k++) begin
          if (!gv && in_valid[(m_last + k) % 4]) begin gv = 1; g = (m_last + k) % 4; end
        end
      end
      exp_rdy = (gv && ld) ? 4'(1 << g) : 4'b0000;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("[TB] FAIL rand_rdy cyc%0d: got %b expected %b", cyc, in_ready, exp_rdy); end
      if (m_valid && out_ready) begin
        total++;
        if (pend_q.size() == 0) begin
          bad++; $display("[TB] FAIL rand_order cyc%0d: got handshake with no pending word expected none", cyc);
        end else begin
          exp_word = pend_q.pop_front();
          if ({out_ch, out_data} !== exp_word) begin
            bad++; $display("[TB] FAIL rand_order cyc%0d: got %h expected %h", cyc, {out_ch, out_data}, exp_word);
          end
        end
        m_cnt++;
      end
      if (gv && ld && in_valid[g]) begin
        m_valid = 1; m_data = in_data[g*8 +: 8]; m_ch = 2'(g);
        pend_q.push_back({m_ch, m_data});
        if (mode == 1'b1) m_last = g;
      end else if (ld) begin
        m_valid = 0;
      end
      @(negedge clk);
      total++; if (out_valid !== m_valid) begin bad++; $display("[TB] FAIL rand_vld cyc%0d: got %b expected %b", cyc, out_valid, m_valid); end
      total++; if (xfer_cnt !== m_cnt) begin bad++; $display("[TB] FAIL rand_cnt cyc%0d: got %0d expected %0d", cyc, xfer_cnt, m_cnt); end
      if (m_valid) begin
        total++;
        if (out_data !== m_data || out_ch !== m_ch) begin
          bad++; $display("[TB] FAIL rand_out cyc%0d: got %h/%0d expected %h/%0d", cyc, out_data, out_ch, m_data, m_ch);
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    mode_3 = 1'b0; sel_3 = 2'd0; in_valid_3 = 3'b001; out_ready_3 = 1'b1;
    repeat (65536) @(negedge clk);
    total++; if (xfer_cnt !== 16'hFFFF || xfer_cnt_3 !== 16'hFFFF) begin bad++; $display("[TB] FAIL cnt_max: got %h/%h expected ffff", xfer_cnt, xfer_cnt_3); end
    @(negedge clk);
    total++; if (xfer_cnt !== 16'h0000 || xfer_cnt_3 !== 16'h0000) begin bad++; $display("[TB] FAIL cnt_wrap: got %h/%h expected 0000", xfer_cnt, xfer_cnt_3); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_skip_wrap();
    test_backpressure();
    test_oob_sel();
    test_random();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
